// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop sync, counter debounce and press/release
// pulses, plus a stretched active-low SoC reset derived from debounced key 0.
module key_conditioner #(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                soc_reset_n,
  output logic [1:0]          rst_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    HOLD       = 2'd1,
    RUN        = 2'd2
  } rst_state_t;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;

    // Sync flops hold the inverted (1 = pressed) sense, so reset them to the unpressed 0.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1     <= ~key_n[k];
        sync2     <= sync1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (sync2 == level_q) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level_q   <= sync2;
          cnt       <= '0;
          press_q   <= sync2;
          release_q <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
  end

  rst_state_t    state;
  logic [HW-1:0] hold_cnt;

  // soc_reset_n is loaded alongside the state so it is high exactly while state is RUN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= RST_ASSERT;
      hold_cnt    <= '0;
      soc_reset_n <= 1'b0;
    end else begin
      case (state)
        RST_ASSERT: begin
          soc_reset_n <= 1'b0;
          if (!key_level[0]) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (key_level[0]) begin
            state       <= RST_ASSERT;
            soc_reset_n <= 1'b0;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= RUN;
            soc_reset_n <= 1'b1;
          end else begin
            hold_cnt    <= hold_cnt + 1'b1;
            soc_reset_n <= 1'b0;
          end
        end
        RUN: begin
          if (key_level[0]) begin
            state       <= RST_ASSERT;
            soc_reset_n <= 1'b0;
          end else begin
            soc_reset_n <= 1'b1;
          end
        end
        default: begin
          state       <= RST_ASSERT;
          soc_reset_n <= 1'b0;
        end
      endcase
    end
  end

  assign rst_state = state;

endmodule
